// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and the matching 16x receiver.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Clocks per oversample tick, truncated; clamped to 1 so tiny clocks still tick.
  function automatic int calc_baud_div(input longint clk, input longint baud,
                                       input longint ovs = UART_OVERSAMPLE);
    longint d;
    d = clk / (baud * ovs);
    return (d < 1) ? 1 : int'(d);
  endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Oversample tick generator: one-cycle tick every DIV clocks, restartable via clr.
module uart_baud_tick_gen #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1));
    cnt_d = (clr || tick) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO; frames go out back-to-back while data is queued.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         I_sys_clk,
  input  logic                         I_rst,
  input  logic [7:0]                   I_tx_data,
  input  logic                         I_tx_valid,
  output logic                         o_tx_ready,
  output logic                         o_tx_serial_data,
  output logic                         o_tx_busy,
  output logic                         o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0]  o_fifo_count
);

  localparam int DIV = calc_baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(UART_DATA_BITS);

  tx_state_t                 state_q, state_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic [TW-1:0]             tcnt_q, tcnt_d;
  logic [BW-1:0]             bcnt_q, bcnt_d;
  logic                      line_q, line_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic [7:0]                mem_q [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]               count_q, count_d;

  logic wr_en, pop, fifo_empty, baud_clr, baud_tick, bit_end;

  uart_baud_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk  (I_sys_clk),
    .rst  (I_rst),
    .clr  (baud_clr),
    .tick (baud_tick)
  );

  assign o_tx_ready       = (count_q != (AW + 1)'(FIFO_DEPTH));
  assign o_tx_serial_data = line_q;
  assign o_tx_busy        = busy_q;
  assign o_tx_done        = done_q;
  assign o_fifo_count     = count_q;

  assign wr_en      = I_tx_valid && o_tx_ready;
  assign fifo_empty = (count_q == '0);
  assign bit_end    = baud_tick && (tcnt_q == TW'(OVERSAMPLE - 1));

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    tcnt_d   = tcnt_q;
    bcnt_d   = bcnt_q;
    done_d   = 1'b0;
    pop      = 1'b0;
    baud_clr = 1'b0;

    if (state_q != IDLE && baud_tick) begin
      tcnt_d = bit_end ? '0 : tcnt_q + TW'(1);
    end

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          shreg_d  = mem_q[rd_ptr_q];
          tcnt_d   = '0;
          baud_clr = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          bcnt_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bcnt_q == BW'(UART_DATA_BITS - 1)) begin
            state_d = STOP;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          done_d = 1'b1;
          // Chain straight into the next start bit so queued frames have no gap.
          if (!fifo_empty) begin
            pop      = 1'b1;
            shreg_d  = mem_q[rd_ptr_q];
            tcnt_d   = '0;
            baud_clr = 1'b1;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      START:   line_d = 1'b0;
      DATA:    line_d = shreg_q[0];
      default: line_d = 1'b1;
    endcase
    busy_d   = (state_q != IDLE) || !fifo_empty;
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW + 1)'(wr_en) - (AW + 1)'(pop);
  end

  always_ff @(posedge I_sys_clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= I_tx_data;
    end
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      tcnt_q   <= '0;
      bcnt_q   <= '0;
      line_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      tcnt_q   <= tcnt_d;
      bcnt_q   <= bcnt_d;
      line_q   <= line_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at a scaled clock: DIV=3, so one bit is 48 clocks.
module tb_uart_tx;

  localparam int BIT   = 48;
  localparam int FRAME = 10 * BIT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       ready, line, busy, done;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  int         st_q[$];
  int         done_cnt = 0;
  int         frame_err = 0;

  int         mon_ncyc = 0;
  int         mon_cnt = 0;
  int         mon_idx = 0;
  bit         mon_active = 1'b0;
  logic       mon_prev = 1'b1;
  logic [7:0] mon_sh = 8'h00;

  uart_tx #(
    .CLK_FREQ   (470000),
    .BAUD_RATE  (9600),
    .OVERSAMPLE (16),
    .FIFO_DEPTH (4)
  ) dut (
    .I_sys_clk        (clk),
    .I_rst            (rst),
    .I_tx_data        (tx_data),
    .I_tx_valid       (tx_valid),
    .o_tx_ready       (ready),
    .o_tx_serial_data (line),
    .o_tx_busy        (busy),
    .o_tx_done        (done),
    .o_fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Mid-bit sampling receiver; a reset abandons any frame in flight.
  initial begin
    forever begin
      @(negedge clk);
      mon_ncyc++;
      if (done === 1'b1) done_cnt++;
      if (rst) begin
        mon_active = 1'b0;
        mon_prev   = 1'b1;
      end else begin
        if (!mon_active) begin
          if (mon_prev === 1'b1 && line === 1'b0) begin
            mon_active = 1'b1;
            mon_cnt    = 0;
            st_q.push_back(mon_ncyc);
          end
        end else begin
          mon_cnt++;
        end
        if (mon_active && (mon_cnt % BIT) == BIT / 2) begin
          mon_idx = mon_cnt / BIT;
          if (mon_idx == 0) begin
            if (line !== 1'b0) frame_err++;
          end else if (mon_idx <= 8) begin
            mon_sh = {line, mon_sh[7:1]};
          end else begin
            if (line !== 1'b1) frame_err++;
            rx_q.push_back(mon_sh);
            $display("rx byte %02h at cycle %0d", mon_sh, mon_ncyc);
            mon_active = 1'b0;
          end
        end
        mon_prev = line;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic put(input logic [7:0] b, output bit acc);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    acc      = ready;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    $display("tx write %02h accepted=%0d", b, acc);
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", busy, 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_line_low(input string tag, input int budget);
    int k = 0;
    while (line !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, line, 0);
  endtask

  bit         acc;
  int         acc_n, bad, k, d0, maxc;
  logic [7:0] vec3 [5] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};

  initial begin
    // Test 1: reset state and idle stability
    repeat (5) @(posedge clk);
    #1;
    chk("t1_rst_line", line, 1);
    chk("t1_rst_ready", ready, 1);
    chk("t1_rst_count", fifo_count, 0);
    chk("t1_rst_busy", busy, 0);
    chk("t1_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (2000) begin
      @(negedge clk);
      if (line !== 1'b1 || ready !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0) bad++;
    end
    chk("t1_idle_stable", bad, 0);

    // Test 2: single byte 0x77, latency and done/busy timing
    rx_q.delete(); st_q.delete(); d0 = done_cnt;
    put(8'h77, acc);
    chk("t2_accept", acc, 1);
    @(posedge clk); #1;
    chk("t2_line_pop_edge", line, 1);
    @(posedge clk); #1;
    chk("t2_line_start", line, 0);
    k = 0;
    while (done !== 1'b1 && k < FRAME + 50) begin
      @(negedge clk);
      k++;
    end
    chk("t2_done_time", k, FRAME);
    chk("t2_busy_at_done", busy, 1);
    @(negedge clk);
    chk("t2_done_width", done, 0);
    chk("t2_busy_fall", busy, 0);
    wait_rx(1, FRAME);
    chk("t2_rx_count", rx_q.size(), 1);
    if (rx_q.size() >= 1) chk("t2_rx_byte", rx_q[0], 8'h77);
    chk("t2_done_pulses", done_cnt - d0, 1);
    wait_idle(FRAME);

    // Test 3: burst of five writes on consecutive cycles
    rx_q.delete(); st_q.delete(); d0 = done_cnt; acc_n = 0;
    for (int i = 0; i < 5; i++) begin
      put(vec3[i], acc);
      acc_n += int'(acc);
    end
    chk("t3_accepted", acc_n, 5);
    chk("t3_ready_full", ready, 0);
    chk("t3_count_full", fifo_count, 4);
    wait_rx(5, 6 * FRAME);
    chk("t3_rx_count", rx_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < rx_q.size()) chk($sformatf("t3_rx_byte%0d", i), rx_q[i], vec3[i]);
    end
    bad = 0;
    for (int i = 0; i + 1 < st_q.size(); i++) begin
      if (st_q[i + 1] - st_q[i] != FRAME) bad++;
    end
    chk("t3_gapless", bad, 0);
    wait_idle(2 * FRAME);
    chk("t3_done_pulses", done_cnt - d0, 5);

    // Test 4: hold valid with 0x55 against a full FIFO
    rx_q.delete(); st_q.delete(); acc_n = 0; maxc = 0;
    @(negedge clk);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (ready === 1'b1) acc_n++;
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    $display("tx hold 55 accepted=%0d max_count=%0d", acc_n, maxc);
    chk("t4_max_count", maxc, 4);
    wait_rx(acc_n, (acc_n + 2) * FRAME);
    chk("t4_rx_equals_sent", rx_q.size(), acc_n);
    bad = 0;
    foreach (rx_q[i]) if (rx_q[i] !== 8'h55) bad++;
    chk("t4_rx_values", bad, 0);
    wait_idle(2 * FRAME);

    // Test 5: reset in the middle of data bit 4 of 0x0F with two bytes queued
    rx_q.delete(); st_q.delete();
    put(8'h0F, acc);
    put(8'hAA, acc);
    put(8'hBB, acc);
    wait_line_low("t5_start_seen", 20);
    repeat (5 * BIT + BIT / 2) @(negedge clk);
    chk("t5_mid_bit4", line, 0);
    chk("t5_queued", fifo_count, 2);
    d0 = done_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_rst_line", line, 1);
    chk("t5_rst_count", fifo_count, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ready", ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3 * FRAME) @(negedge clk);
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_no_rx", rx_q.size(), 0);
    put(8'h12, acc);
    wait_rx(1, 2 * FRAME);
    chk("t5_post_rx_count", rx_q.size(), 1);
    if (rx_q.size() >= 1) chk("t5_post_rx_byte", rx_q[0], 8'h12);
    wait_idle(2 * FRAME);

    // Test 6: write during the stop bit chains the next frame with no gap
    rx_q.delete(); st_q.delete();
    put(8'hC3, acc);
    wait_line_low("t6_start_seen", 20);
    repeat (9 * BIT + BIT / 2) @(negedge clk);
    chk("t6_in_stop", line, 1);
    put(8'h00, acc);
    wait_rx(2, 3 * FRAME);
    chk("t6_rx_count", rx_q.size(), 2);
    if (rx_q.size() >= 2) begin
      chk("t6_rx_first", rx_q[0], 8'hC3);
      chk("t6_rx_second", rx_q[1], 8'h00);
    end
    if (st_q.size() >= 2) chk("t6_start_spacing", st_q[1] - st_q[0], FRAME);
    else chk("t6_start_spacing", st_q.size(), 2);
    wait_idle(2 * FRAME);

    chk("framing_errors", frame_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
